// File: rtl/clock_phase_sequencer.sv
// Five-phase strobe sequencer (INST, DATA, REG, MUU, PC) for a single-cycle core.
// Optional macro STEP_DEBOUNCE_EN adds a consecutive-sample debouncer on the step button.
module clock_phase_sequencer #(
    parameter int PHASE_LEN       = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    output logic        inst_clock,
    output logic        data_clock,
    output logic        reg_clock,
    output logic        muu_clock,
    output logic        pc_clock,
    output logic        busy,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        INST,
        DATA,
        REG,
        MUU,
        PC
    } state_t;

    localparam int DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
`ifdef STEP_DEBOUNCE_EN
    localparam int StepThreshold = DEBOUNCE_CYCLES;
`else
    localparam int StepThreshold = 1;
`endif
    localparam logic [DebW-1:0] HighTarget = DebW'(StepThreshold - 1);
    localparam logic [3:0]      PhaseLast  = 4'(PHASE_LEN - 1);

    state_t            state_q, state_d;
    logic [3:0]        phaseCnt_q, phaseCnt_d;
    logic [15:0]       instrCount_q, instrCount_d;
    logic              syncMeta_q, syncStep_q;
    logic [1:0]        validPipe_q;
    logic              armed_q, armed_d;
    logic [DebW-1:0]   highCnt_q, highCnt_d;
    logic              stepEvent;
    logic              lastPhase;

    // Step press qualification. The synchronizer outputs only reflect the real
    // button two edges after reset, so the press must first be seen low on a
    // valid sample; this keeps a button held through reset from firing.
    always_comb begin
        highCnt_d = highCnt_q;
        armed_d   = armed_q;
        stepEvent = syncStep_q && armed_q && (highCnt_q == HighTarget);
        if (!syncStep_q) begin
            highCnt_d = '0;
            if (validPipe_q[1]) begin
                armed_d = 1'b1;
            end
        end else begin
            if (highCnt_q != HighTarget) begin
                highCnt_d = highCnt_q + DebW'(1);
            end
            if (stepEvent) begin
                armed_d = 1'b0;
            end
        end
    end

    // Phase sequencing: every non-idle state holds for PHASE_LEN cycles and a
    // started cycle always runs through PC, whatever run does meanwhile.
    always_comb begin
        state_d      = state_q;
        instrCount_d = instrCount_q;
        lastPhase    = (phaseCnt_q == PhaseLast);
        case (state_q)
            IDLE: if (run || stepEvent) state_d = INST;
            INST: if (lastPhase) state_d = DATA;
            DATA: if (lastPhase) state_d = REG;
            REG:  if (lastPhase) state_d = MUU;
            MUU:  if (lastPhase) state_d = PC;
            PC: begin
                if (lastPhase) begin
                    instrCount_d = instrCount_q + 16'd1;
                    state_d      = run ? INST : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d != state_q) || (state_q == IDLE)) begin
            phaseCnt_d = '0;
        end else begin
            phaseCnt_d = phaseCnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phaseCnt_q   <= '0;
            instrCount_q <= '0;
            syncMeta_q   <= 1'b0;
            syncStep_q   <= 1'b0;
            validPipe_q  <= '0;
            armed_q      <= 1'b0;
            highCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            phaseCnt_q   <= phaseCnt_d;
            instrCount_q <= instrCount_d;
            syncMeta_q   <= step;
            syncStep_q   <= syncMeta_q;
            validPipe_q  <= {validPipe_q[0], 1'b1};
            armed_q      <= armed_d;
            highCnt_q    <= highCnt_d;
        end
    end

    assign inst_clock  = (state_q == INST);
    assign data_clock  = (state_q == DATA);
    assign reg_clock   = (state_q == REG);
    assign muu_clock   = (state_q == MUU);
    assign pc_clock    = (state_q == PC);
    assign busy        = (state_q != IDLE);
    assign instr_count = instrCount_q;

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// Self-checking bench for clock_phase_sequencer: vector table, directed corner
// sequences and random run/step traffic against a cycle-position reference model.
module tb_clock_phase_sequencer;

    localparam int PhaseLen       = 2;
    localparam int DebounceCycles = 4;
`ifdef STEP_DEBOUNCE_EN
    localparam int StepThreshold = DebounceCycles;
`else
    localparam int StepThreshold = 1;
`endif

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        instClock, dataClock, regClock, muuClock, pcClock;
    logic        busy;
    logic [15:0] instrCount;
    logic [4:0]  dutStrobes;

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the instruction cycle (-1 = idle).
    int          modelPos;
    logic [15:0] modelCount;
    bit          seen1, seen2;
    bit          lowSeen;
    int          highRun;
    int          sinceReset;

    typedef struct {
        logic        rst;
        logic        run;
        logic        step;
        logic [4:0]  strobes;
        logic        busy;
        logic [15:0] count;
    } vector_t;

    vector_t vecs[$];

    clock_phase_sequencer #(
        .PHASE_LEN(PhaseLen),
        .DEBOUNCE_CYCLES(DebounceCycles)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .step(step),
        .inst_clock(instClock),
        .data_clock(dataClock),
        .reg_clock(regClock),
        .muu_clock(muuClock),
        .pc_clock(pcClock),
        .busy(busy),
        .instr_count(instrCount)
    );

    assign dutStrobes = {instClock, dataClock, regClock, muuClock, pcClock};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(logic r, logic ru, logic s, logic [4:0] st, logic [15:0] cnt);
        vector_t v;
        v.rst = r; v.run = ru; v.step = s; v.strobes = st; v.busy = |st; v.count = cnt;
        vecs.push_back(v);
    endfunction

    // The button counts as pressed on the StepThreshold-th consecutive high
    // sample as seen two edges late, provided a genuine low was seen before.
    function automatic void modelClock(bit r, bit ru, bit s);
        bit press;
        if (r) begin
            modelPos = -1; modelCount = 16'h0000;
            seen1 = 0; seen2 = 0; lowSeen = 0; highRun = 0; sinceReset = 0;
        end else begin
            press = 0;
            if (seen2) begin
                highRun++;
                if (lowSeen && highRun == StepThreshold) begin
                    press = 1;
                    lowSeen = 0;
                end
            end else begin
                highRun = 0;
                if (sinceReset >= 2) lowSeen = 1;
            end
            if (modelPos < 0) begin
                if (ru || press) modelPos = 0;
            end else begin
                modelPos++;
                if (modelPos == 5 * PhaseLen) begin
                    modelCount = modelCount + 16'd1;
                    modelPos = ru ? 0 : -1;
                end
            end
            seen2 = seen1;
            seen1 = s;
            sinceReset++;
        end
    endfunction

    function automatic logic [4:0] modelStrobes();
        logic [4:0] base;
        base = 5'b10000;
        if (modelPos < 0) return 5'b00000;
        return base >> (modelPos / PhaseLen);
    endfunction

    task automatic checkValue(string name, logic [15:0] actual, logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(bit r, bit ru, bit s);
        reset = r; run = ru; step = s;
        @(posedge clk);
        modelClock(r, ru, s);
        #1;
    endtask

    task automatic checkOutput(string tag);
        checkValue({tag, ".strobes"}, {11'b0, dutStrobes}, {11'b0, modelStrobes()});
        checkValue({tag, ".busy"}, {15'b0, busy}, {15'b0, modelPos >= 0});
        checkValue({tag, ".count"}, instrCount, modelCount);
    endtask

    task automatic stepModel(bit r, bit ru, bit s, string tag);
        applyStimulus(r, ru, s);
        checkOutput(tag);
    endtask

    initial begin
        logic [15:0] countBefore;
        bit          runLvl;
        int          stepLeft;
        bit          rr, ss;

        reset = 1'b1; run = 1'b0; step = 1'b0;
        modelClock(1, 0, 0);

        // Reset followed by one run-driven cycle, then a step press.
        addVec(1, 0, 0, 5'b00000, 16'd0);
        for (int i = 0; i < 10; i++) begin
            addVec(0, 1, 0, 5'b10000 >> (i / 2), 16'd0);
        end
        addVec(0, 0, 0, 5'b00000, 16'd1);
        addVec(0, 0, 0, 5'b00000, 16'd1);
`ifndef STEP_DEBOUNCE_EN
        addVec(0, 0, 1, 5'b00000, 16'd1);
        addVec(0, 0, 1, 5'b00000, 16'd1);
        addVec(0, 0, 1, 5'b10000, 16'd1);
        addVec(0, 0, 1, 5'b10000, 16'd1);
        addVec(0, 0, 1, 5'b01000, 16'd1);
        addVec(0, 0, 1, 5'b01000, 16'd1);
        addVec(0, 0, 0, 5'b00100, 16'd1);
        addVec(0, 0, 0, 5'b00100, 16'd1);
        addVec(0, 0, 0, 5'b00010, 16'd1);
        addVec(0, 0, 0, 5'b00010, 16'd1);
        addVec(0, 0, 0, 5'b00001, 16'd1);
        addVec(0, 0, 0, 5'b00001, 16'd1);
        addVec(0, 0, 0, 5'b00000, 16'd2);
        addVec(0, 0, 0, 5'b00000, 16'd2);
`endif
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].step);
            checkValue($sformatf("vec%0d.strobes", i), {11'b0, dutStrobes}, {11'b0, vecs[i].strobes});
            checkValue($sformatf("vec%0d.busy", i), {15'b0, busy}, {15'b0, vecs[i].busy});
            checkValue($sformatf("vec%0d.count", i), instrCount, vecs[i].count);
        end

        // Forty cycles of run from reset give four complete instructions.
        stepModel(1, 0, 0, "run40.reset");
        for (int i = 0; i < 40; i++) stepModel(0, 1, 0, "run40");
        stepModel(0, 0, 0, "run40.end");
        checkValue("run40.count", instrCount, 16'd4);
        checkValue("run40.idle", {15'b0, busy}, 16'd0);

        // Run dropped during DATA: the cycle still completes.
        countBefore = modelCount;
        for (int i = 0; i < 3; i++) stepModel(0, 1, 0, "dropRun");
        for (int i = 0; i < 8; i++) stepModel(0, 0, 0, "dropRun");
        checkValue("dropRun.count", instrCount, countBefore + 16'd1);
        checkValue("dropRun.idle", {15'b0, busy}, 16'd0);

        // Reset landing in REG clears everything on the next cycle.
        for (int i = 0; i < 5; i++) stepModel(0, 1, 0, "midReset");
        checkValue("midReset.inReg", {11'b0, dutStrobes}, 16'h0004);
        applyStimulus(1, 1, 0);
        checkValue("midReset.strobes", {11'b0, dutStrobes}, 16'd0);
        checkValue("midReset.count", instrCount, 16'd0);
        checkValue("midReset.busy", {15'b0, busy}, 16'd0);

        // Step held high through reset must not start a cycle.
        stepModel(1, 0, 1, "heldStep");
        stepModel(1, 0, 1, "heldStep");
        for (int i = 0; i < 10; i++) stepModel(0, 0, 1, "heldStep");
        checkValue("heldStep.idle", {15'b0, busy}, 16'd0);
        for (int i = 0; i < 3; i++) stepModel(0, 0, 0, "heldStep");

`ifdef STEP_DEBOUNCE_EN
        // Debounced: a 3-sample pulse is ignored, a 5-sample pulse is one press.
        countBefore = modelCount;
        for (int i = 0; i < 3; i++) stepModel(0, 0, 1, "deb3");
        for (int i = 0; i < 8; i++) stepModel(0, 0, 0, "deb3");
        checkValue("deb3.count", instrCount, countBefore);
        for (int i = 0; i < 5; i++) stepModel(0, 0, 1, "deb5");
        for (int i = 0; i < 16; i++) stepModel(0, 0, 0, "deb5");
        checkValue("deb5.count", instrCount, countBefore + 16'd1);
`else
        // Undebounced: a two-cycle glitch counts as a single press.
        countBefore = modelCount;
        for (int i = 0; i < 2; i++) stepModel(0, 0, 1, "glitch");
        for (int i = 0; i < 14; i++) stepModel(0, 0, 0, "glitch");
        checkValue("glitch.count", instrCount, countBefore + 16'd1);
`endif

        // Counter wrap: preload the count register, then run one more cycle.
        dut.instrCount_q = 16'hFFFF;
        modelCount = 16'hFFFF;
        #1;
        checkValue("wrap.preload", instrCount, 16'hFFFF);
        stepModel(0, 1, 0, "wrap");
        for (int i = 0; i < 10; i++) stepModel(0, 0, 0, "wrap");
        checkValue("wrap.count", instrCount, 16'h0000);

        // Random run levels, button pulses and rare resets.
        runLvl = 0;
        stepLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) runLvl = ~runLvl;
            if (stepLeft > 0) begin
                ss = 1;
                stepLeft--;
            end else if ($urandom_range(0, 14) == 0) begin
                ss = 1;
                stepLeft = $urandom_range(0, 6);
            end else begin
                ss = 0;
            end
            stepModel(rr, runLvl, ss, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
